upd7800_cpgen: RTL



---
 rtl/upd7800_cpgen_pkg.sv | 29 ++
 rtl/upd7800_rst_stretch.sv | 36 +++
 rtl/upd7800_cpgen.sv | 111 +++++++++++
 3 files changed

// File: rtl/upd7800_cpgen_pkg.sv
// Shared types and parameter limits for the uPD7800 clock-phase / reset sequencer.
package upd7800_cpgen_pkg;

  typedef enum logic [1:0] {
    PH_CP1P = 2'd0,
    PH_CP1N = 2'd1,
    PH_CP2P = 2'd2,
    PH_CP2N = 2'd3
  } cp_phase_t;

  typedef enum logic {
    RUN  = 1'b0,
    IDLE = 1'b1
  } cg_state_t;

  localparam int DIV_MIN        = 1;
  localparam int RST_CYCLES_MIN = 0;
  localparam int RST_CYCLES_MAX = 255;

  function automatic cp_phase_t phase_next(input cp_phase_t p);
    case (p)
      PH_CP1P: return PH_CP1N;
      PH_CP1N: return PH_CP2P;
      PH_CP2P: return PH_CP2N;
      default: return PH_CP1P;
    endcase
  endfunction

endpackage

// File: rtl/upd7800_rst_stretch.sv
// Holds CPU_RESETB low for RST_CYCLES machine cycles, releasing it on a CP1P edge.
module upd7800_rst_stretch
  import upd7800_cpgen_pkg::*;
#(
  parameter int RST_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cp2n_set,
  input  logic cp1p_set,
  input  logic stalled,
  output logic resetb
);

  localparam logic [7:0] RST_LIM = 8'(RST_CYCLES);

  logic [7:0] cnt_q;
  logic       at_lim;

  assign at_lim = (cnt_q == RST_LIM);

  // Strobe inputs are the set pulses, so the count and release line up with
  // the edge that asserts the strobe rather than the cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      resetb <= 1'b0;
    end else begin
      if (!resetb && cp2n_set && !stalled && !at_lim)
        cnt_q <= cnt_q + 8'd1;
      if (!resetb && cp1p_set && !stalled && at_lim)
        resetb <= 1'b1;
    end
  end

endmodule

// File: rtl/upd7800_cpgen.sv
// Four-phase strobe generator and reset sequencer for the uPD7800 core.
// Define CPGEN_STALL_EN to build in the STALL_REQ/STALL_ACK freeze handshake.
module upd7800_cpgen
  import upd7800_cpgen_pkg::*;
#(
  parameter int DIV        = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic STALL_REQ,
  output logic STALL_ACK,
  output logic CP1_POSEDGE,
  output logic CP1_NEGEDGE,
  output logic CP2_POSEDGE,
  output logic CP2_NEGEDGE,
  output logic CP1,
  output logic CP2,
  output logic CPU_RESETB
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  if (DIV < DIV_MIN || RST_CYCLES < RST_CYCLES_MIN || RST_CYCLES > RST_CYCLES_MAX) begin : g_param_err
    $error("upd7800_cpgen: DIV or RST_CYCLES out of range");
  end

  logic [PW-1:0] pre_q;
  cp_phase_t     ph_q, ph_nx;
  cg_state_t     st_q, st_d;
  logic          stall_take, stall_rel;
  logic          step, wrap;
  logic [3:0]    stb_d;

  // Stall decisions: sample at the CP2N cycle, release whenever REQ drops.
  always_comb begin
    stall_take = 1'b0;
    stall_rel  = 1'b0;
`ifdef CPGEN_STALL_EN
    stall_take = (st_q == RUN) && CP2_NEGEDGE && STALL_REQ;
    stall_rel  = (st_q == IDLE) && !STALL_REQ;
`endif
  end

`ifndef CPGEN_STALL_EN
  logic unused_stall_req;
  assign unused_stall_req = STALL_REQ;
`endif

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) st_q <= RUN;
    else       st_q <= st_d;
  end

  // Next-state
  always_comb begin
    st_d = st_q;
    if (stall_take)     st_d = IDLE;
    else if (stall_rel) st_d = RUN;
  end

  // Outputs (next values). The release edge already counts as a run step so a
  // stall inserts exactly its own length into the strobe sequence.
  always_comb begin
    step  = ((st_q == RUN) && !stall_take) || stall_rel;
    wrap  = step && (pre_q == PRE_LAST);
    ph_nx = phase_next(ph_q);
    stb_d = '0;
    if (wrap) stb_d[ph_nx] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre_q       <= '0;
      ph_q        <= PH_CP2N;
      CP1_POSEDGE <= 1'b0;
      CP1_NEGEDGE <= 1'b0;
      CP2_POSEDGE <= 1'b0;
      CP2_NEGEDGE <= 1'b0;
      CP1         <= 1'b0;
      CP2         <= 1'b0;
      STALL_ACK   <= 1'b0;
    end else begin
      pre_q       <= (step && !wrap) ? pre_q + PW'(1) : '0;
      if (wrap) ph_q <= ph_nx;
      CP1_POSEDGE <= stb_d[PH_CP1P];
      CP1_NEGEDGE <= stb_d[PH_CP1N];
      CP2_POSEDGE <= stb_d[PH_CP2P];
      CP2_NEGEDGE <= stb_d[PH_CP2N];
      if (stb_d[PH_CP1P])      CP1 <= 1'b1;
      else if (stb_d[PH_CP1N]) CP1 <= 1'b0;
      if (stb_d[PH_CP2P])      CP2 <= 1'b1;
      else if (stb_d[PH_CP2N]) CP2 <= 1'b0;
      STALL_ACK   <= (st_d == IDLE);
    end
  end

  upd7800_rst_stretch #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rst_stretch (
    .clk      (CLK),
    .rst      (RESET),
    .cp2n_set (stb_d[PH_CP2N]),
    .cp1p_set (stb_d[PH_CP1P]),
    .stalled  (st_q == IDLE),
    .resetb   (CPU_RESETB)
  );

endmodule
